// File: rtl/mem_bus_initiator.sv
// MEM-stage load/store initiator: turns pipeline requests into APB-style SETUP/ACCESS transfers.
// Optional MEM_BUS_MISALIGN_CHECK_EN rejects misaligned accesses with an error instead of masking low address bits.
module mem_bus_initiator #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_strb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [3:0]  pstrb,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] ST_SB = 3'd0, ST_SH = 3'd1, ST_SW = 3'd2, ST_LB = 3'd3;
  localparam logic [2:0] ST_LH = 3'd4, ST_LW = 3'd5, ST_LBU = 3'd6, ST_LHU = 3'd7;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [1:0]         lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]        paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [3:0]         pstrb_q, pstrb_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic [2:0]  op_c;
  logic [1:0]  lo_c;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c;
  logic        reject_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] ld_data_c;

  // Request decode: mismatched we/encoding collapses to a full word, low bits masked per size.
  always_comb begin
    op_c = req_strb;
    if (req_we && req_strb > ST_SW) op_c = ST_SW;
    if (!req_we && req_strb < ST_LB) op_c = ST_LW;
    lo_c    = req_addr[1:0];
    strb_c  = 4'b0000;
    wdata_c = '0;
    case (op_c)
      ST_SB: begin
        strb_c  = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      ST_SH: begin
        lo_c    = {req_addr[1], 1'b0};
        strb_c  = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      ST_SW: begin
        lo_c    = 2'b00;
        strb_c  = 4'b1111;
        wdata_c = req_wdata;
      end
      ST_LH, ST_LHU: lo_c = {req_addr[1], 1'b0};
      ST_LW:         lo_c = 2'b00;
      default:       ;
    endcase
  end

`ifdef MEM_BUS_MISALIGN_CHECK_EN
  assign reject_c = ((op_c == ST_SH || op_c == ST_LH || op_c == ST_LHU) && req_addr[0]) ||
                    ((op_c == ST_SW || op_c == ST_LW) && (req_addr[1:0] != 2'b00));
`else
  assign reject_c = 1'b0;
`endif

  // Load lane extraction and extension from the latched access.
  always_comb begin
    case (lo_q)
      2'd1:    byte_c = prdata[15:8];
      2'd2:    byte_c = prdata[23:16];
      2'd3:    byte_c = prdata[31:24];
      default: byte_c = prdata[7:0];
    endcase
    half_c = lo_q[1] ? prdata[31:16] : prdata[15:0];
    case (op_q)
      ST_LB:   ld_data_c = {{24{byte_c[7]}}, byte_c};
      ST_LBU:  ld_data_c = {24'h0, byte_c};
      ST_LH:   ld_data_c = {{16{half_c[15]}}, half_c};
      ST_LHU:  ld_data_c = {16'h0, half_c};
      default: ld_data_c = prdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = op_c;
          lo_d  = lo_c;
          cnt_d = '0;
          if (reject_c) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = req_we;
            paddr_d   = {req_addr[31:2], 2'b00};
            pstrb_d   = strb_c;
            pwdata_d  = wdata_c;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = DONE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (pslverr || pwrite_q) ? '0 : ld_data_c;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d     = DONE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      op_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // stall must see the request in the same cycle it is presented, and stays low in reset.
  assign stall = rstn && ((state_q == IDLE && req_valid) || state_q == SETUP || state_q == ACCESS);

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pstrb     = pstrb_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Bench for mem_bus_initiator: directed vector table, reset corners, and random traffic against a reference model.
module tb_mem_bus_initiator;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rstn, req_valid, req_we;
  logic [2:0]  req_strb;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err, psel, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  mem_bus_initiator #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we), .req_strb(req_strb),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  typedef struct {
    int          rsp_cyc;
    logic        err;
    logic [31:0] rdata;
    logic        psel_seen;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    logic        pwrite;
    logic [31:0] pwdata;
  } exp_t;

  typedef struct {
    int          rsp_cyc;
    logic        err;
    logic [31:0] rdata;
    logic        psel_seen;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [63:0] stall_mask;
    logic        unstable;
    logic        rsp_after;
  } obs_t;

  typedef struct {
    logic        we;
    logic [2:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: sizes/offsets and lane replication computed arithmetically from the access rules.
  function automatic exp_t model(input logic we, input logic [2:0] strb, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                                 input logic slverr);
    exp_t e;
    logic [2:0]  op;
    int          size, off;
    bit          sgn, mis;
    logic [31:0] v, mask;
    op = strb;
    if (we && strb > 3'd2) op = 3'd2;
    if (!we && strb < 3'd3) op = 3'd5;
    case (op)
      3'd0, 3'd3, 3'd6: size = 1;
      3'd1, 3'd4, 3'd7: size = 2;
      default:          size = 4;
    endcase
    sgn = (op == 3'd3 || op == 3'd4);
    mis = (int'(addr[1:0]) % size) != 0;
`ifndef MEM_BUS_MISALIGN_CHECK_EN
    mis = 1'b0;
`endif
    off  = (int'(addr[1:0]) / size) * size;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    e.paddr  = addr & ~32'h3;
    e.pwrite = we;
    e.pstrb  = we ? 4'(((1 << size) - 1) << off) : 4'b0000;
    for (int i = 0; i < 4; i++) e.pwdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    if (mis) begin
      e.psel_seen = 1'b0;
      e.rsp_cyc   = 1;
      e.err       = 1'b1;
      e.rdata     = '0;
    end else begin
      e.psel_seen = 1'b1;
      if (waits >= int'(TO)) begin
        e.rsp_cyc = 2 + int'(TO);
        e.err     = 1'b1;
        e.rdata   = '0;
      end else begin
        e.rsp_cyc = 3 + waits;
        e.err     = slverr;
        v = (rdata >> (8 * off)) & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        e.rdata = (we || slverr) ? 32'h0 : v;
      end
    end
    return e;
  endfunction

  // Presents one request starting at a negedge and acts as the responder until the response pulse.
  task automatic run_txn(input logic we, input logic [2:0] strb, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                         input logic slverr, output obs_t o);
    int cyc, acc;
    o = '{default: '0};
    o.rsp_cyc = -1;
    req_valid = 1'b1; req_we = we; req_strb = strb; req_addr = addr; req_wdata = wdata;
    cyc = 0; acc = 0;
    while (o.rsp_cyc < 0 && cyc < 60) begin
      #1;
      if (stall) o.stall_mask[cyc] = 1'b1;
      if (psel) begin
        if (!o.psel_seen) begin
          o.psel_seen = 1'b1;
          o.paddr = paddr; o.pstrb = pstrb; o.pwrite = pwrite; o.pwdata = pwdata;
        end else if (paddr !== o.paddr || pstrb !== o.pstrb || pwrite !== o.pwrite ||
                     pwdata !== o.pwdata) begin
          o.unstable = 1'b1;
        end
      end
      if (psel && penable) begin
        pready = (acc >= waits);
        acc++;
      end else begin
        pready = 1'b0;
      end
      pslverr = pready & slverr;
      prdata  = pready ? rdata : $urandom;
      if (rsp_valid) begin
        o.rsp_cyc = cyc;
        o.err     = rsp_err;
        o.rdata   = rsp_rdata;
        req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    pready    = 1'b0;
    #1 o.rsp_after = rsp_valid;
  endtask

  task automatic compare(input string tag, input exp_t e, input obs_t o, input logic we);
    chk({tag, ".rsp_cyc"}, 64'(o.rsp_cyc), 64'(e.rsp_cyc));
    chk({tag, ".rsp_err"}, 64'(o.err), 64'(e.err));
    chk({tag, ".rsp_rdata"}, 64'(o.rdata), 64'(e.rdata));
    chk({tag, ".rsp_one_cycle"}, 64'(o.rsp_after), 64'(0));
    chk({tag, ".stall"}, o.stall_mask, (64'h1 << e.rsp_cyc) - 64'h1);
    chk({tag, ".psel_seen"}, 64'(o.psel_seen), 64'(e.psel_seen));
    if (e.psel_seen) begin
      chk({tag, ".paddr"}, 64'(o.paddr), 64'(e.paddr));
      chk({tag, ".pstrb"}, 64'(o.pstrb), 64'(e.pstrb));
      chk({tag, ".pwrite"}, 64'(o.pwrite), 64'(e.pwrite));
      chk({tag, ".stable"}, 64'(o.unstable), 64'(0));
      if (we) chk({tag, ".pwdata"}, 64'(o.pwdata), 64'(e.pwdata));
    end
  endtask

  function automatic vec_t mkv(input logic we, input logic [2:0] strb, input logic [31:0] addr,
                               input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                               input logic slverr, input int cyc, input logic err,
                               input logic [31:0] erd, input logic epsel, input logic [31:0] epaddr,
                               input logic [3:0] epstrb, input logic [31:0] epwdata);
    vec_t v;
    v.we = we; v.strb = strb; v.addr = addr; v.wdata = wdata; v.waits = waits;
    v.rdata = rdata; v.slverr = slverr;
    v.e.rsp_cyc = cyc; v.e.err = err; v.e.rdata = erd; v.e.psel_seen = epsel;
    v.e.paddr = epaddr; v.e.pstrb = epstrb; v.e.pwrite = we; v.e.pwdata = epwdata;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    obs_t o;
    exp_t e;
    logic        r_we, r_sl;
    logic [2:0]  r_strb;
    logic [31:0] r_addr, r_wd, r_rd;
    int          r_waits;

    vecs.push_back(mkv(1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 32'h0, 0, 3, 0, 32'h0, 1, 32'h104, 4'hF, 32'hDEADBEEF));
    vecs.push_back(mkv(0, 3'd3, 32'h103, 32'h0, 2, 32'h80C2F17F, 0, 5, 0, 32'hFFFFFF80, 1, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mkv(0, 3'd6, 32'h103, 32'h0, 2, 32'h80C2F17F, 0, 5, 0, 32'h00000080, 1, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mkv(0, 3'd4, 32'h102, 32'h0, 2, 32'h80C2F17F, 0, 5, 0, 32'hFFFF80C2, 1, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mkv(0, 3'd7, 32'h102, 32'h0, 2, 32'h80C2F17F, 0, 5, 0, 32'h000080C2, 1, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mkv(1, 3'd0, 32'h201, 32'h0000005A, 0, 32'h0, 0, 3, 0, 32'h0, 1, 32'h200, 4'b0010, 32'h5A5A5A5A));
    vecs.push_back(mkv(1, 3'd1, 32'h206, 32'h1234ABCD, 1, 32'h0, 0, 4, 0, 32'h0, 1, 32'h204, 4'b1100, 32'hABCDABCD));
    vecs.push_back(mkv(0, 3'd3, 32'h101, 32'h0, 0, 32'h80C2F17F, 0, 3, 0, 32'hFFFFFFF1, 1, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mkv(0, 3'd5, 32'h300, 32'h0, 16, 32'h11111111, 0, 18, 1, 32'h0, 1, 32'h300, 4'h0, 32'h0));
    vecs.push_back(mkv(0, 3'd5, 32'h304, 32'h0, 15, 32'h22222222, 0, 18, 0, 32'h22222222, 1, 32'h304, 4'h0, 32'h0));
    vecs.push_back(mkv(0, 3'd5, 32'h400, 32'h0, 0, 32'h12345678, 1, 3, 1, 32'h0, 1, 32'h400, 4'h0, 32'h0));
    vecs.push_back(mkv(1, 3'd3, 32'h10C, 32'hCAFEF00D, 0, 32'h0, 0, 3, 0, 32'h0, 1, 32'h10C, 4'hF, 32'hCAFEF00D));
    vecs.push_back(mkv(0, 3'd0, 32'h110, 32'h0, 0, 32'h89ABCDEF, 0, 3, 0, 32'h89ABCDEF, 1, 32'h110, 4'h0, 32'h0));
`ifdef MEM_BUS_MISALIGN_CHECK_EN
    vecs.push_back(mkv(0, 3'd5, 32'h102, 32'h0, 0, 32'h0BADF00D, 0, 1, 1, 32'h0, 0, 32'h0, 4'h0, 32'h0));
`else
    vecs.push_back(mkv(0, 3'd5, 32'h102, 32'h0, 0, 32'h0BADF00D, 0, 3, 0, 32'h0BADF00D, 1, 32'h100, 4'h0, 32'h0));
`endif

    // Reset with a pending request: everything quiet.
    rstn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_strb = 3'd2;
    req_addr = 32'h104; req_wdata = 32'hDEADBEEF;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 64'(stall), 64'(0));
    chk("rst.psel", 64'(psel), 64'(0));
    chk("rst.penable", 64'(penable), 64'(0));
    chk("rst.pwrite", 64'(pwrite), 64'(0));
    chk("rst.paddr", 64'(paddr), 64'(0));
    chk("rst.pstrb", 64'(pstrb), 64'(0));
    chk("rst.pwdata", 64'(pwdata), 64'(0));
    chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst.rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst.rsp_err", 64'(rsp_err), 64'(0));

    // Release mid-cycle: nothing starts until the next edge.
    #1 rstn = 1'b1;
    #1 chk("release.psel_before_edge", 64'(psel), 64'(0));
    @(negedge clk); #1;
    chk("release.setup", 64'({psel, penable}), 64'(2'b10));
    @(negedge clk); #1;
    chk("release.access", 64'({psel, penable}), 64'(2'b11));
    // Asynchronous reset in ACCESS drops the bus without a clock.
    rstn = 1'b0;
    #1 chk("async_rst.bus", 64'({psel, penable, stall}), 64'(0));
    req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].strb, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
              vecs[i].rdata, vecs[i].slverr, o);
      compare($sformatf("vec%0d", i), vecs[i].e, o, vecs[i].we);
    end

    for (int n = 0; n < 60; n++) begin
      r_we    = 1'($urandom);
      r_strb  = 3'($urandom);
      r_addr  = $urandom;
      r_wd    = $urandom;
      r_rd    = $urandom;
      r_sl    = ($urandom_range(0, 7) == 0);
      r_waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
      e = model(r_we, r_strb, r_addr, r_wd, r_waits, r_rd, r_sl);
      run_txn(r_we, r_strb, r_addr, r_wd, r_waits, r_rd, r_sl, o);
      compare($sformatf("rnd%0d", n), e, o, r_we);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
